// File: rtl/mem_read_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory read port. Each port queues one
// request; returned words are steered back to their owner by a latency-matched tag pipeline.
module mem_read_arbiter #(
  parameter int unsigned ADDRESS_SIZE   = 28,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MEM_LATENCY    = 2,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                    clk_memory,
  input  logic                    reset_n,
  input  logic                    a_read_en,
  input  logic [ADDRESS_SIZE-1:0] a_read_addr,
  output logic [DATA_WIDTH-1:0]   a_read_data,
  output logic                    a_read_valid,
  output logic                    a_busy,
  input  logic                    b_read_en,
  input  logic [ADDRESS_SIZE-1:0] b_read_addr,
  output logic [DATA_WIDTH-1:0]   b_read_data,
  output logic                    b_read_valid,
  output logic                    b_busy,
  output logic                    mem_rd,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [1:0]              err_overflow
);

  typedef enum logic [1:0] {StIdle, StPend, StFlight} port_st_e;

  port_st_e                st_q     [2];
  port_st_e                st_d     [2];
  logic [ADDRESS_SIZE-1:0] addr_q   [2];
  logic [ADDRESS_SIZE-1:0] addr_d   [2];
  logic [ADDRESS_SIZE-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0]   data_q   [2];
  logic [DATA_WIDTH-1:0]   data_d   [2];
  logic [1:0]              req, pend, err_q, err_d, vld_q, vld_d;
  logic                    issue, gnt_id, last_q, last_d;
  logic [MEM_LATENCY:0]    tag_vld_q, tag_vld_d, tag_id_q, tag_id_d;
  logic                    ret_vld, ret_id;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDRESS_SIZE-1:0] mem_addr_q, mem_addr_d;

  assign req         = {b_read_en, a_read_en};
  assign req_addr[0] = a_read_addr;
  assign req_addr[1] = b_read_addr;
  assign pend[0]     = (st_q[0] == StPend);
  assign pend[1]     = (st_q[1] == StPend);
  assign ret_vld     = tag_vld_q[MEM_LATENCY];
  assign ret_id      = tag_id_q[MEM_LATENCY];

  // State register
  always_ff @(posedge clk_memory) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= StIdle;
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      err_q      <= '0;
      vld_q      <= '0;
      last_q     <= 1'b1;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        st_q[i]   <= st_d[i];
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      err_q      <= err_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Next-state logic: grant, per-port FSM, tag pipeline and return capture
  always_comb begin
    issue = |pend;
    if (&pend) begin
      // last_q starts at B so that A wins the first tie
      gnt_id = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_q;
    end else begin
      gnt_id = pend[1];
    end
    last_d = issue ? gnt_id : last_q;

    for (int i = 0; i < 2; i++) begin
      st_d[i]   = st_q[i];
      addr_d[i] = addr_q[i];
      err_d[i]  = err_q[i] | (req[i] & (st_q[i] != StIdle));
      unique case (st_q[i])
        StIdle: begin
          if (req[i]) begin
            st_d[i]   = StPend;
            addr_d[i] = req_addr[i];
          end
        end
        StPend:   if (issue && (gnt_id == 1'(i))) st_d[i] = StFlight;
        StFlight: if (ret_vld && (ret_id == 1'(i))) st_d[i] = StIdle;
        default:  st_d[i] = StIdle;
      endcase
      vld_d[i]  = ret_vld && (ret_id == 1'(i));
      data_d[i] = vld_d[i] ? mem_rdata : data_q[i];
    end

    mem_rd_d   = issue;
    mem_addr_d = issue ? addr_q[gnt_id] : mem_addr_q;
    tag_vld_d  = {tag_vld_q[MEM_LATENCY-1:0], issue};
    tag_id_d   = {tag_id_q[MEM_LATENCY-1:0], gnt_id};
  end

  // Outputs, all taken from registers
  always_comb begin
    a_busy       = (st_q[0] != StIdle);
    b_busy       = (st_q[1] != StIdle);
    a_read_valid = vld_q[0];
    b_read_valid = vld_q[1];
    a_read_data  = data_q[0];
    b_read_data  = data_q[1];
    mem_rd       = mem_rd_q;
    mem_addr     = mem_addr_q;
    err_overflow = err_q;
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: memory model, scoreboard queues checked by negedge monitors,
// a table of uncontended reads and hand sequences for contention, overflow and reset.
module tb_mem_read_arbiter;
  localparam int AW = 28;
  localparam int DW = 16;
  localparam int MemLatency = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          a_read_en, b_read_en;
  logic [AW-1:0] a_read_addr, b_read_addr;
  logic [DW-1:0] a_read_data, b_read_data;
  logic          a_read_valid, b_read_valid, a_busy, b_busy;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    err_overflow;
  logic [DW-1:0] f_a_read_data, f_b_read_data;
  logic          f_a_read_valid, f_b_read_valid, f_a_busy, f_b_busy, f_mem_rd;
  logic [AW-1:0] f_mem_addr;
  logic [1:0]    f_err_overflow;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .MEM_LATENCY(MemLatency),
                     .FIXED_PRIORITY(0)) u_dut (
    .clk_memory(clk), .reset_n(reset_n),
    .a_read_en(a_read_en), .a_read_addr(a_read_addr), .a_read_data(a_read_data),
    .a_read_valid(a_read_valid), .a_busy(a_busy),
    .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_data(b_read_data),
    .b_read_valid(b_read_valid), .b_busy(b_busy),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .err_overflow(err_overflow)
  );

  mem_read_arbiter #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .MEM_LATENCY(MemLatency),
                     .FIXED_PRIORITY(1)) u_fix (
    .clk_memory(clk), .reset_n(reset_n),
    .a_read_en(a_read_en), .a_read_addr(a_read_addr), .a_read_data(f_a_read_data),
    .a_read_valid(f_a_read_valid), .a_busy(f_a_busy),
    .b_read_en(b_read_en), .b_read_addr(b_read_addr), .b_read_data(f_b_read_data),
    .b_read_valid(f_b_read_valid), .b_busy(f_b_busy),
    .mem_rd(f_mem_rd), .mem_addr(f_mem_addr), .mem_rdata(mem_rdata),
    .err_overflow(f_err_overflow)
  );

  typedef struct {logic [31:0] val; int at;} exp_t;
  typedef struct {bit port; logic [AW-1:0] addr; logic [DW-1:0] data;} vec_t;

  exp_t          iss_q[$], ra_q[$], rb_q[$];
  logic [AW-1:0] fq[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem_func(input logic [AW-1:0] a);
    if (a == 28'h10) return 16'hBEEF;
    return a[15:0] ^ 16'h5A3C;
  endfunction

  // Memory model: word for an address sampled with mem_rd appears MemLatency cycles later
  logic [DW-1:0] pipe [MemLatency];
  always @(posedge clk) begin
    pipe[0] <= mem_rd ? mem_func(mem_addr) : 16'hDEAD;
    for (int i = 1; i < MemLatency; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MemLatency-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int which, input logic [31:0] val, input int at);
    exp_t e;
    e.val = val;
    e.at  = at;
    case (which)
      0:       iss_q.push_back(e);
      1:       ra_q.push_back(e);
      default: rb_q.push_back(e);
    endcase
  endtask

  task automatic pop_cmp(input string name, input int which, input logic [31:0] act);
    exp_t e;
    bit   ok = 1'b1;
    case (which)
      0:       if (iss_q.size() == 0) ok = 1'b0; else e = iss_q.pop_front();
      1:       if (ra_q.size() == 0) ok = 1'b0; else e = ra_q.pop_front();
      default: if (rb_q.size() == 0) ok = 1'b0; else e = rb_q.pop_front();
    endcase
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: unexpected strobe value %h at cycle %0d, required none", name, act, cyc);
    end else begin
      chk({name, " value"}, act, e.val);
      chk({name, " cycle"}, cyc, e.at);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rd === 1'b1) pop_cmp("mem_rd", 0, 32'(mem_addr));
    if (a_read_valid === 1'b1) pop_cmp("a_read", 1, 32'(a_read_data));
    if (b_read_valid === 1'b1) pop_cmp("b_read", 2, 32'(b_read_data));
    if (f_mem_rd === 1'b1) fq.push_back(f_mem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // One uncontended request in the current cycle with nominal-latency expectations
  task automatic req_single(input bit port, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    int c = cyc;
    push_exp(0, 32'(addr), c + 2);
    push_exp(port ? 2 : 1, 32'(data), c + MemLatency + 3);
    if (port) begin b_read_en = 1'b1; b_read_addr = addr; end
    else begin a_read_en = 1'b1; a_read_addr = addr; end
    tick();
    a_read_en = 1'b0;
    b_read_en = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while ((a_busy || b_busy || iss_q.size() != 0 || ra_q.size() != 0 || rb_q.size() != 0)
           && n < max) begin
      tick();
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", max);
    end
    tick();
  endtask

  task automatic zero_check(input string name);
    chk({name, " data"}, {a_read_data, b_read_data}, 32'h0);
    chk({name, " ctl"}, {a_read_valid, b_read_valid, a_busy, b_busy, mem_rd, err_overflow}, 0);
    chk({name, " mem_addr"}, 32'(mem_addr), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   c;
    vecs[0] = '{1'b0, 28'h0000010, 16'hBEEF};
    vecs[1] = '{1'b1, 28'h0ABCDEF, 16'h97D3};
    vecs[2] = '{1'b0, 28'hFFFFFFF, 16'hA5C3};
    vecs[3] = '{1'b1, 28'h0000000, 16'h5A3C};
    vecs[4] = '{1'b0, 28'h1234567, 16'h1F5B};

    a_read_en = 1'b0; b_read_en = 1'b0; a_read_addr = '0; b_read_addr = '0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    zero_check("reset");

    // Uncontended A read at cycle 10, busy window 11..14, valid at 15
    while (cyc < 10) tick();
    c = cyc;
    req_single(1'b0, 28'h0000010, 16'hBEEF);
    for (int k = 1; k <= 5; k++) begin
      chk("a_busy window", a_busy, k <= 4);
      tick();
    end
    wait_idle(40);

    for (int i = 0; i < 5; i++) begin
      req_single(vecs[i].port, vecs[i].addr, vecs[i].data);
      wait_idle(40);
    end

    // Simultaneous A and B after reset: A wins the first tie
    do_reset();
    c = cyc;
    push_exp(0, 32'h100, c + 2);
    push_exp(0, 32'h200, c + 3);
    push_exp(1, 32'(mem_func(28'h100)), c + 5);
    push_exp(2, 32'(mem_func(28'h200)), c + 6);
    a_read_en = 1'b1; a_read_addr = 28'h100;
    b_read_en = 1'b1; b_read_addr = 28'h200;
    tick();
    a_read_en = 1'b0; b_read_en = 1'b0;
    wait_idle(40);

    // Continuous traffic: each port re-requests in its own valid cycle, grants alternate
    c = cyc;
    for (int t = 0; t <= 16; t++) begin
      a_read_en = (t % 5 == 0);
      b_read_en = (t == 0) || (t % 5 == 1 && t > 1);
      a_read_addr = 28'h1000 + 28'(t);
      b_read_addr = 28'h2000 + 28'(t);
      if (a_read_en) begin
        if (t > 0) chk("a accept on valid", a_read_valid, 1'b1);
        push_exp(0, 32'(a_read_addr), c + t + 2);
        push_exp(1, 32'(mem_func(a_read_addr)), c + t + 5);
      end
      if (b_read_en) begin
        push_exp(0, 32'(b_read_addr), c + t + ((t == 0) ? 3 : 2));
        push_exp(2, 32'(mem_func(b_read_addr)), c + t + ((t == 0) ? 6 : 5));
      end
      tick();
    end
    a_read_en = 1'b0; b_read_en = 1'b0;
    wait_idle(60);
    chk("no overflow streaming", err_overflow, 2'b00);

    // Tie after an A grant: round-robin gives B, fixed priority still gives A
    req_single(1'b0, 28'h300, mem_func(28'h300));
    wait_idle(40);
    fq.delete();
    c = cyc;
    push_exp(0, 32'h500, c + 2);
    push_exp(0, 32'h400, c + 3);
    push_exp(2, 32'(mem_func(28'h500)), c + 5);
    push_exp(1, 32'(mem_func(28'h400)), c + 6);
    a_read_en = 1'b1; a_read_addr = 28'h400;
    b_read_en = 1'b1; b_read_addr = 28'h500;
    tick();
    a_read_en = 1'b0; b_read_en = 1'b0;
    wait_idle(40);
    chk("fixed issue count", fq.size(), 2);
    if (fq.size() >= 2) begin
      chk("fixed first grant", 32'(fq[0]), 32'h400);
      chk("fixed second grant", 32'(fq[1]), 32'h500);
    end

    // B overflow: second request two cycles later is dropped and flagged
    req_single(1'b1, 28'h600, mem_func(28'h600));
    tick();
    b_read_en = 1'b1; b_read_addr = 28'h700;
    tick();
    b_read_en = 1'b0;
    chk("err_overflow set", err_overflow, 2'b10);
    wait_idle(40);
    req_single(1'b1, 28'h800, mem_func(28'h800));
    wait_idle(40);
    chk("err_overflow sticky", err_overflow, 2'b10);

    // Reset the cycle after A's mem_rd: read abandoned, no strobe afterwards
    c = cyc;
    push_exp(0, 32'h900, c + 2);
    a_read_en = 1'b1; a_read_addr = 28'h900;
    tick();
    a_read_en = 1'b0;
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    zero_check("mid reset");
    repeat (8) tick();
    req_single(1'b0, 28'hA00, mem_func(28'hA00));
    wait_idle(40);

    chk("issue queue drained", iss_q.size(), 0);
    chk("a queue drained", ra_q.size(), 0);
    chk("b queue drained", rb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
